// File: rtl/fixed_dot_acc_if.sv
// Product-beat stream in, one saturated dot-product result out, plus sync clear.
interface fixed_dot_acc_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output clear, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_count
  );

  modport slave (
    input  clear, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_count
  );
endinterface

// File: rtl/fixed_dot_acc.sv
// Q8.8 dot-product accumulator: result registered 1 cycle after the closing beat.
// Backpressure: in_ready drops while a result is held until out_ready takes it.
module fixed_dot_acc #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16,
  parameter int ACC_W  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  fixed_dot_acc_if.slave bus
);
  typedef enum logic {ACC, OUT} state_t;

  // Clamp bounds of the signed DATA_W result, held at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_t                   state, state_nxt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_nxt;
  logic                     take;
  logic                     close;
  logic [DATA_W-1:0]        sat_data;
  logic                     sat_flag;

  assign sum      = acc + {{(ACC_W-DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};
  assign cnt_nxt  = cnt + CNT_W'(1);

  always_comb begin
    sat_data = sum[DATA_W-1:0];
    sat_flag = 1'b0;
    if (sum > SAT_MAX) begin
      sat_data = SAT_MAX[DATA_W-1:0];
      sat_flag = 1'b1;
    end else if (sum < SAT_MIN) begin
      sat_data = SAT_MIN[DATA_W-1:0];
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  // A full counter closes the vector on its own so the count never wraps.
  always_comb begin
    state_nxt    = state;
    take         = 1'b0;
    close        = 1'b0;
    bus.in_ready  = (state == ACC);
    bus.out_valid = (state == OUT);
    if (bus.clear) begin
      state_nxt = ACC;
    end else begin
      case (state)
        ACC: begin
          if (bus.in_valid) begin
            take = 1'b1;
            if (bus.in_last || cnt_nxt == {CNT_W{1'b1}}) begin
              close     = 1'b1;
              state_nxt = OUT;
            end
          end
        end
        OUT: begin
          if (bus.out_ready) state_nxt = ACC;
        end
        default: state_nxt = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      cnt           <= '0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
      bus.out_count <= '0;
    end else if (bus.clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (take) begin
      if (close) begin
        bus.out_data  <= sat_data;
        bus.out_sat   <= sat_flag;
        bus.out_count <= cnt_nxt;
        acc           <= '0;
        cnt           <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt_nxt;
      end
    end
  end
endmodule
